pad_uart_rx: RTL and testbench

- Serial receive front-end inside the user project; consumes the five user pads io[37:33] (local index 0..4 = pad 33..37).
- Local pad 0 is the UART RX input. It is synchronised, oversampled and deframed as 8N1, LSB first.
- Received bytes are buffered in a small FIFO and handed to core logic over a valid/ready port.
- Local pads 1..4 are outputs that drive status indicators.

---
 rtl/pad_uart_rx.sv | 177 +++++++++++++++++
 tb/tb_pad_uart_rx.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_uart_rx.sv
// pad_uart_rx: 8N1 serial receiver on user pad 33 (local pad 0).
// Bytes land in a small FIFO that the core drains over a valid/ready port.
// Pads 34..37 (local 1..4) show busy, overrun, frame error and FIFO non-empty.
//
// Consumer handshake: rx_valid is high whenever the FIFO holds a byte and
// rx_data is its head. A byte is consumed on a clock edge where
// rx_valid && rx_ready. rx_data does not change while rx_valid && !rx_ready.
module pad_uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [4:0] io_in,
    output logic [4:0] io_out,
    output logic [4:0] io_oeb,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic       clr_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic          busy;
    logic          rx_meta;
    logic          rxs;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          overrun;
    logic          frame_err;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          stop_sample;
    logic          push;
    logic          pop;
    logic          set_ovr;
    logic          set_fe;

    // Pads 34..37 are driven as indicators only; their input side carries nothing.
    logic unused_pads;
    assign unused_pads = ^io_in[4:1];

    // Two-flop synchroniser on the rx pad; idles high so reset looks like an idle line.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= io_in[0];
            rxs     <= rx_meta;
        end
    end

    // Deframing FSM: half a bit to the start-bit centre, then one full bit per sample.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state   <= START;
                        busy    <= 1'b1;
                        bit_cnt <= HALF_BIT;
                    end
                end
                START: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (rxs) begin
                        // Line went back high before mid start bit: a glitch, not a frame.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state   <= DATA;
                        bit_cnt <= FULL_BIT;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        shreg[bit_idx] <= rxs;
                        bit_cnt        <= FULL_BIT;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so a start bit right behind it is not missed.
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign stop_sample = (state == STOP) && (bit_cnt == '0);
    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop         = !fifo_empty && rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
    assign push        = stop_sample && rxs && (!fifo_full || pop);
    assign set_ovr     = stop_sample && rxs && fifo_full && !pop;
    assign set_fe      = stop_sample && !rxs;

    // Byte FIFO; storage is cleared on reset so rx_data reads zero when flushed.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= shreg;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (set_ovr) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (set_fe) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

    assign rx_data  = mem[rd_ptr[AW-1:0]];
    assign rx_valid = !fifo_empty;
    assign io_out   = {rx_valid, frame_err, overrun, busy, 1'b0};
    assign io_oeb   = 5'b00001;

endmodule

// File: tb/tb_pad_uart_rx.sv
// Bench for pad_uart_rx: directed scenarios plus randomized frames, glitches,
// consumer back-pressure and error clears, checked every cycle against a
// frame-level model (byte queue, sticky flags, busy windows).
module tb_pad_uart_rx;
    localparam int CPB       = 16;
    localparam int DEPTH     = 4;
    // Edge of the stop-bit sample, counted from the first edge that sees the start bit:
    // 2 synchroniser edges, half a bit to the start centre, 9 more bit times.
    localparam int FRAME_LAT = 2 + CPB / 2 + 9 * CPB;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_line;
    logic [3:0] junk;
    logic       rx_ready;
    logic       clr_err;
    logic [4:0] io_in;
    logic [4:0] io_out;
    logic [4:0] io_oeb;
    logic [7:0] rx_data;
    logic       rx_valid;

    always #5 clk = ~clk;

    assign io_in = {junk, rx_line};

    pad_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .clr_err  (clr_err)
    );

    // ---------------- model state ----------------
    int         cyc = 0;      // index of the next clock edge to happen
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];     // bytes the FIFO must hold, head first
    logic       m_ovr = 1'b0;
    logic       m_fe = 1'b0;
    logic       m_busy = 1'b0;
    int         ev_cyc[$];    // stop-sample edges of frames in flight
    logic       ev_ok[$];
    logic [7:0] ev_dat[$];
    int         bf_q[$];      // receiver busy windows [from, to) in edge numbers
    int         bt_q[$];
    logic       rand_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc - 1);
        end
    endtask

    // Model update at every edge from the inputs the DUT samples on that edge.
    initial begin
        forever begin
            int   n;
            logic pop;
            logic do_push;
            logic set_o;
            logic set_f;
            logic [7:0] pdat;
            @(posedge clk);
            n = cyc;
            if (rst_n !== 1'b1) begin
                exp_q.delete();
                ev_cyc.delete();
                ev_ok.delete();
                ev_dat.delete();
                bf_q.delete();
                bt_q.delete();
                m_ovr  = 1'b0;
                m_fe   = 1'b0;
                m_busy = 1'b0;
            end else begin
                pop     = (exp_q.size() > 0) && (rx_ready === 1'b1);
                do_push = 1'b0;
                set_o   = 1'b0;
                set_f   = 1'b0;
                pdat    = 8'h00;
                if (ev_cyc.size() > 0 && ev_cyc[0] == n) begin
                    pdat = ev_dat[0];
                    if (!ev_ok[0]) set_f = 1'b1;
                    else if (exp_q.size() < DEPTH || pop) do_push = 1'b1;
                    else set_o = 1'b1;
                    void'(ev_cyc.pop_front());
                    void'(ev_ok.pop_front());
                    void'(ev_dat.pop_front());
                end
                if (pop) void'(exp_q.pop_front());
                if (do_push) exp_q.push_back(pdat);
                if (clr_err === 1'b1) begin
                    m_ovr = 1'b0;
                    m_fe  = 1'b0;
                end
                if (set_o) m_ovr = 1'b1;
                if (set_f) m_fe = 1'b1;
                while (bt_q.size() > 0 && bt_q[0] <= n) begin
                    void'(bf_q.pop_front());
                    void'(bt_q.pop_front());
                end
                m_busy = 1'b0;
                foreach (bf_q[i]) if (bf_q[i] <= n && n < bt_q[i]) m_busy = 1'b1;
            end
            cyc = n + 1;
        end
    end

    // Scoreboard compare on every falling edge.
    initial begin
        forever begin
            logic       e_valid;
            logic [4:0] e_out;
            logic [7:0] e_dat;
            @(negedge clk);
            if (cyc >= 1) begin
                e_valid = (exp_q.size() > 0);
                e_dat   = e_valid ? exp_q[0] : 8'h00;
                e_out   = {e_valid, m_fe, m_ovr, m_busy, 1'b0};
                checks++;
                if (io_out !== e_out || io_oeb !== 5'b00001 || rx_valid !== e_valid ||
                    (e_valid && rx_data !== e_dat)) begin
                    errors++;
                    if (errors < 40)
                        $display("FAIL cycle_cmp edge=%0d io_out=%b exp=%b oeb=%b valid=%b exp=%b data=%02h exp=%02h",
                                 cyc - 1, io_out, e_out, io_oeb, rx_valid, e_valid, rx_data, e_dat);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_line = 1'b1;
        repeat (n) step();
    endtask

    // Returns at the falling edge that follows edge e.
    task automatic wait_edge(input int e);
        int guard = 0;
        while (cyc < e + 1 && guard < 5000) begin
            step();
            guard++;
        end
        if (cyc != e + 1) begin
            checks++;
            errors++;
            $display("FAIL wait_edge: at edge %0d wanted %0d", cyc - 1, e);
        end
        @(negedge clk);
    endtask

    // Drives the first nbits of an 8N1 frame; the stop bit value is stop_v.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int nbits);
        int         n0;
        logic [9:0] bits;
        n0   = cyc;
        bits = {stop_v, b, 1'b0};
        ev_cyc.push_back(n0 + FRAME_LAT);
        ev_ok.push_back(stop_v);
        ev_dat.push_back(b);
        bf_q.push_back(n0 + 2);
        bt_q.push_back(n0 + FRAME_LAT);
        if (!stop_v) begin
            // Line still low when the receiver rearms: seen as a start that fails mid-bit.
            bf_q.push_back(n0 + FRAME_LAT + 1);
            bt_q.push_back(n0 + FRAME_LAT + 1 + CPB / 2);
        end
        for (int i = 0; i < nbits; i++) begin
            rx_line = bits[i];
            repeat (CPB) step();
        end
        rx_line = 1'b1;
    endtask

    task automatic send_glitch(input int len);
        int n0;
        n0 = cyc;
        bf_q.push_back(n0 + 2);
        bt_q.push_back(n0 + 2 + CPB / 2);
        rx_line = 1'b0;
        repeat (len) step();
        rx_line = 1'b1;
        repeat (CPB / 2 + 4) step();
    endtask

    task automatic drain_expect(input logic [7:0] first, input int n, input string name);
        rx_ready = 1'b0;
        step();
        rx_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check(name, rx_data, 32'(first) + 32'(k));
            step();
        end
        @(negedge clk);
        check({name, "_empty"}, rx_valid, 0);
        step();
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n0;
        rst_n    = 1'b0;
        rx_line  = 1'b1;
        junk     = 4'h0;
        rx_ready = 1'b0;
        clr_err  = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_io_out", io_out, 0);
        check("rst_io_oeb", io_oeb, 5'b00001);
        step();
        rst_n = 1'b1;
        idle(4);

        // 1: single frame with a ready consumer
        rx_ready = 1'b1;
        n0 = cyc;
        fork
            send_frame(8'hA5, 1'b1, 10);
            begin
                wait_edge(n0 + 1);
                check("t1_busy_early", io_out[1], 0);
                wait_edge(n0 + 2);
                check("t1_busy", io_out[1], 1);
                wait_edge(n0 + FRAME_LAT);
                check("t1_valid", rx_valid, 1);
                check("t1_data", rx_data, 8'hA5);
                check("t1_flags", io_out[3:2], 0);
                wait_edge(n0 + FRAME_LAT + 1);
                check("t1_valid_gone", rx_valid, 0);
                check("t1_idle", io_out[1], 0);
            end
        join
        idle(4);

        // 2: overrun with a stalled consumer
        rx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1, 10);
            if (k == 4) begin
                @(negedge clk);
                check("t2_valid4", rx_valid, 1);
                check("t2_head4", rx_data, 8'h01);
                check("t2_no_ovr4", io_out[2], 0);
            end
        end
        @(negedge clk);
        check("t2_overrun", io_out[2], 1);
        check("t2_head5", rx_data, 8'h01);
        drain_expect(8'h01, 4, "t2_drain");
        pulse_clr();
        @(negedge clk);
        check("t2_ovr_clr", io_out[2], 0);
        step();

        // 3: pop in the same cycle as the push into a full FIFO
        for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, 10);
        n0 = cyc;
        fork
            send_frame(8'h05, 1'b1, 10);
            begin
                while (cyc < n0 + FRAME_LAT) step();
                rx_ready = 1'b1;
                step();
                rx_ready = 1'b0;
            end
        join
        @(negedge clk);
        check("t3_no_ovr", io_out[2], 0);
        check("t3_head", rx_data, 8'h02);
        drain_expect(8'h02, 4, "t3_drain");

        // 4: framing error, recovery, clear/set collision
        send_frame(8'h3C, 1'b0, 10);
        idle(4);
        @(negedge clk);
        check("t4_fe", io_out[3], 1);
        check("t4_idle", io_out[1], 0);
        check("t4_no_push", rx_valid, 0);
        step();
        rx_ready = 1'b1;
        n0 = cyc;
        fork
            send_frame(8'h7E, 1'b1, 10);
            begin
                wait_edge(n0 + FRAME_LAT);
                check("t4_data", rx_data, 8'h7E);
                check("t4_fe_kept", io_out[3], 1);
            end
        join
        idle(4);
        pulse_clr();
        @(negedge clk);
        check("t4_fe_clr", io_out[3], 0);
        step();
        n0 = cyc;
        fork
            send_frame(8'hC3, 1'b0, 10);
            begin
                while (cyc < n0 + FRAME_LAT) step();
                clr_err = 1'b1;
                step();
                clr_err = 1'b0;
                @(negedge clk);
                check("t4_set_wins", io_out[3], 1);
            end
        join
        idle(4);
        pulse_clr();

        // 5: short glitch is not a frame
        idle(2);
        n0 = cyc;
        fork
            send_glitch(4);
            begin
                wait_edge(n0 + 2);
                check("t5_busy", io_out[1], 1);
                wait_edge(n0 + 2 + CPB / 2);
                check("t5_idle", io_out[1], 0);
                check("t5_flags", io_out[4:2], 0);
            end
        join
        idle(4);

        // 6: reset in the middle of a frame with bytes queued
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 10);
        send_frame(8'h22, 1'b1, 10);
        send_frame(8'h33, 1'b0, 10);
        idle(4);
        send_frame(8'h44, 1'b1, 4);
        rx_line = 1'b0;            // bit 3 of 0x44
        repeat (CPB / 2) step();
        rst_n   = 1'b0;
        rx_line = 1'b1;
        n0 = cyc;
        wait_edge(n0);
        check("t6_valid", rx_valid, 0);
        check("t6_io_out", io_out, 0);
        check("t6_data", rx_data, 0);
        step();
        step();
        rst_n = 1'b1;
        idle(4);
        send_frame(8'h5A, 1'b1, 10);
        @(negedge clk);
        check("t6_fresh", rx_data, 8'h5A);
        drain_expect(8'h5A, 1, "t6_drain");

        // random traffic
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    rx_ready = ($urandom_range(0, 1) == 1);
                    clr_err  = ($urandom_range(0, 19) == 0);
                    junk     = 4'($urandom_range(0, 15));
                    step();
                end
                rx_ready = 1'b0;
                clr_err  = 1'b0;
            end
            begin
                for (int f = 0; f < 24; f++) begin
                    int   kind;
                    logic ok;
                    kind = $urandom_range(0, 9);
                    if (kind == 0) begin
                        send_glitch($urandom_range(1, CPB / 2 - 2));
                    end else begin
                        ok = (kind != 1);
                        send_frame(8'($urandom_range(0, 255)), ok, 10);
                        idle(ok ? $urandom_range(0, 8) : $urandom_range(4, 10));
                    end
                end
                idle(40);
                rand_on = 1'b0;
            end
        join
        idle(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
